// File: rtl/spatz_pkg.sv
// ============================================================================
// Module  : spatz_pkg
// Brief   : Shared VRF types and constants for the VRF read path.
// Revision: 1.0
// ============================================================================
`default_nettype none

package spatz_pkg;

    localparam int VregAddrWidth   = 5;
    localparam int VregDataWidth   = 32;
    localparam int VrfReadLenWidth = 8;

    typedef logic [VregAddrWidth-1:0] vreg_addr_t;
    typedef logic [VregDataWidth-1:0] vreg_data_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_e;

endpackage : spatz_pkg

`default_nettype wire

// File: rtl/spatz_operand_fifo.sv
// ============================================================================
// Module  : spatz_operand_fifo
// Brief   : Registered operand FIFO holding data plus a last-word tag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spatz_operand_fifo #(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [CNT_W-1:0]      o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH:0] r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [CNT_W-1:0]    r_count;

    logic w_push;
    logic w_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // Requests against a full/empty buffer are ignored rather than corrupting it.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    assign {o_last, o_data} = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_next(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_next(r_rptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {i_last, i_data};
        end
    end

endmodule : spatz_operand_fifo

`default_nettype wire

// File: rtl/spatz_vrf_reader.sv
// ============================================================================
// Module  : spatz_vrf_reader
// Brief   : Turns a (address, length) burst request into VRF reads and
//           buffers the returned words as a last-tagged operand stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spatz_vrf_reader
    import spatz_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int LEN_WIDTH  = VrfReadLenWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  vreg_addr_t           req_addr_i,
    input  logic [LEN_WIDTH-1:0] req_len_i,
    output vreg_addr_t           vrf_raddr_o,
    output logic                 vrf_re_o,
    input  vreg_data_t           vrf_rdata_i,
    input  logic                 vrf_rvalid_i,
    output logic                 op_valid_o,
    input  logic                 op_ready_i,
    output vreg_data_t           op_data_o,
    output logic                 op_last_o,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    rd_state_e            r_state;
    vreg_addr_t           r_addr;
    logic [LEN_WIDTH-1:0] r_remaining;

    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_rd_done;
    logic             w_rd_last;
    logic             w_pop;
    logic             w_fifo_last;

    assign req_ready_o = (r_state == IDLE);
    assign vrf_re_o    = (r_state == READ) && !w_full;
    assign vrf_raddr_o = r_addr;

    assign w_rd_done = vrf_re_o && vrf_rvalid_i;
    assign w_rd_last = (r_remaining == LEN_WIDTH'(1));

    assign op_valid_o = !w_empty;
    assign w_pop      = op_valid_o && op_ready_i;
    // Stale buffer contents must not leak a last flag out of reset.
    assign op_last_o  = w_fifo_last && op_valid_o;
    assign busy_o     = (r_state == READ) || (w_count != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Zero-length requests are acknowledged and dropped.
                    if (req_valid_i && (req_len_i != '0)) begin
                        r_addr      <= req_addr_i;
                        r_remaining <= req_len_i;
                        r_state     <= READ;
                    end
                end
                READ: begin
                    if (w_rd_done) begin
                        r_addr      <= r_addr + vreg_addr_t'(1);
                        r_remaining <= r_remaining - LEN_WIDTH'(1);
                        if (w_rd_last) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    spatz_operand_fifo #(
        .DEPTH      (FIFO_DEPTH),
        .DATA_WIDTH (VregDataWidth),
        .CNT_W      (CNT_W)
    ) u_operand_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (w_rd_done),
        .i_data  (vrf_rdata_i),
        .i_last  (w_rd_last),
        .i_pop   (w_pop),
        .o_data  (op_data_o),
        .o_last  (w_fifo_last),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

endmodule : spatz_vrf_reader

`default_nettype wire

// File: tb/tb_spatz_vrf_reader.sv
// ============================================================================
// Module  : tb_spatz_vrf_reader
// Brief   : Directed self-checking bench for spatz_vrf_reader.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_spatz_vrf_reader;
    import spatz_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    vreg_addr_t req_addr;
    logic [7:0] req_len;
    vreg_addr_t vrf_raddr;
    logic       vrf_re;
    vreg_data_t vrf_rdata;
    logic       vrf_rvalid;
    logic       op_valid;
    logic       op_ready;
    vreg_data_t op_data;
    logic       op_last;
    logic       busy;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    // VRF model: each word carries its own address so order errors are visible.
    assign vrf_rdata = {16'hDA7A, 11'h000, vrf_raddr};

    spatz_vrf_reader #(
        .FIFO_DEPTH (2),
        .LEN_WIDTH  (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_len_i    (req_len),
        .vrf_raddr_o  (vrf_raddr),
        .vrf_re_o     (vrf_re),
        .vrf_rdata_i  (vrf_rdata),
        .vrf_rvalid_i (vrf_rvalid),
        .op_valid_o   (op_valid),
        .op_ready_i   (op_ready),
        .op_data_o    (op_data),
        .op_last_o    (op_last),
        .busy_o       (busy)
    );

    function automatic logic [31:0] word_of(input int a);
        return {16'hDA7A, 11'h000, 5'(a)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Wait (bounded) for an operand, check it, then step so op_ready can pop it.
    task automatic expect_op(input string tag, input int a, input logic l);
        int n = 0;
        while (!op_valid && n < 8) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 32'(op_valid), 32'd1);
        chk({tag, "_data"}, op_data, word_of(a));
        chk({tag, "_last"}, 32'(op_last), 32'(l));
        step();
    endtask

    task automatic send_req(input int a, input int len);
        req_valid = 1'b1;
        req_addr  = 5'(a);
        req_len   = 8'(len);
        step();
        req_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_re"},        32'(vrf_re),    32'd0);
        chk({tag, "_raddr"},     32'(vrf_raddr), 32'd0);
        chk({tag, "_op_valid"},  32'(op_valid),  32'd0);
        chk({tag, "_op_last"},   32'(op_last),   32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    initial begin
        logic seen_re;
        logic seen_busy;
        logic held;
        logic seen_op;
        int   n_reads;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_len    = '0;
        vrf_rvalid = 1'b0;
        op_ready   = 1'b0;
        step();
        step();
        chk_reset_outputs("rst");
        rst = 1'b0;
        step();

        // Basic burst: addr 4, len 3, full flow.
        vrf_rvalid = 1'b1;
        op_ready   = 1'b1;
        chk("b1_req_ready_idle", 32'(req_ready), 32'd1);
        send_req(4, 3);
        chk("b1_t1_re",       32'(vrf_re),    32'd1);
        chk("b1_t1_raddr",    32'(vrf_raddr), 32'd4);
        chk("b1_t1_op_valid", 32'(op_valid),  32'd0);
        chk("b1_t1_busy",     32'(busy),      32'd1);
        chk("b1_t1_req_rdy",  32'(req_ready), 32'd0);
        step();
        chk("b1_t2_raddr",    32'(vrf_raddr), 32'd5);
        chk("b1_t2_op_valid", 32'(op_valid),  32'd1);
        chk("b1_t2_data",     op_data,        word_of(4));
        chk("b1_t2_last",     32'(op_last),   32'd0);
        step();
        chk("b1_t3_raddr",    32'(vrf_raddr), 32'd6);
        chk("b1_t3_data",     op_data,        word_of(5));
        chk("b1_t3_last",     32'(op_last),   32'd0);
        step();
        chk("b1_t4_req_rdy",  32'(req_ready), 32'd1);
        chk("b1_t4_re",       32'(vrf_re),    32'd0);
        chk("b1_t4_data",     op_data,        word_of(6));
        chk("b1_t4_last",     32'(op_last),   32'd1);
        chk("b1_t4_busy",     32'(busy),      32'd1);
        step();
        chk("b1_t5_op_valid", 32'(op_valid),  32'd0);
        chk("b1_t5_busy",     32'(busy),      32'd0);

        // Zero-length request is consumed without any read.
        seen_re   = 1'b0;
        seen_busy = 1'b0;
        send_req(9, 0);
        for (int i = 0; i < 4; i++) begin
            seen_re   = seen_re | vrf_re;
            seen_busy = seen_busy | busy;
            step();
        end
        chk("z_re_never",   32'(seen_re),   32'd0);
        chk("z_busy_never", 32'(seen_busy), 32'd0);
        chk("z_req_ready",  32'(req_ready), 32'd1);

        // Backpressure: consumer stalled, buffer of 2 fills, then drains in order.
        op_ready = 1'b0;
        send_req(10, 5);
        n_reads = 0;
        for (int i = 0; i < 6; i++) begin
            if (vrf_re && vrf_rvalid) n_reads++;
            step();
        end
        chk("bp_reads",    32'(n_reads),  32'd2);
        chk("bp_re_off",   32'(vrf_re),   32'd0);
        chk("bp_op_valid", 32'(op_valid), 32'd1);
        op_ready = 1'b1;
        expect_op("bp_w0", 10, 1'b0);
        expect_op("bp_w1", 11, 1'b0);
        expect_op("bp_w2", 12, 1'b0);
        expect_op("bp_w3", 13, 1'b0);
        expect_op("bp_w4", 14, 1'b1);
        step();
        chk("bp_idle", 32'(req_ready), 32'd1);

        // VRF stall: rvalid low 3 cycles mid-burst holds the address.
        op_ready = 1'b0;
        send_req(20, 4);
        chk("st_raddr0", 32'(vrf_raddr), 32'd20);
        step();
        vrf_rvalid = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 3; i++) begin
            held = held & vrf_re & (vrf_raddr == 5'd21);
            step();
        end
        chk("st_held", 32'(held), 32'd1);
        vrf_rvalid = 1'b1;
        op_ready   = 1'b1;
        expect_op("st_w0", 20, 1'b0);
        expect_op("st_w1", 21, 1'b0);
        expect_op("st_w2", 22, 1'b0);
        expect_op("st_w3", 23, 1'b1);
        step();

        // Address wrap at all-ones.
        send_req(31, 2);
        chk("wr_raddr_max", 32'(vrf_raddr), 32'd31);
        step();
        chk("wr_raddr_0",   32'(vrf_raddr), 32'd0);
        expect_op("wr_w0", 31, 1'b0);
        expect_op("wr_w1", 0, 1'b1);
        step();

        // Reset mid-burst discards buffered words and the burst.
        op_ready = 1'b0;
        send_req(2, 4);
        step();
        step();
        chk("ra_full_op_valid", 32'(op_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_outputs("ra");
        op_ready = 1'b1;
        seen_op  = 1'b0;
        seen_re  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen_op = seen_op | op_valid;
            seen_re = seen_re | vrf_re;
            step();
        end
        chk("ra_no_ops",   32'(seen_op), 32'd0);
        chk("ra_no_reads", 32'(seen_re), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_spatz_vrf_reader

`default_nettype wire

// File: doc/spatz_vrf_reader.md
SPATZ_VRF_READER -- requirements
Module: spatz_vrf_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning operand buffer entries (legal values 1..8).
REQ-002 SHALL have parameter LEN_WIDTH, default 8, meaning width of the word-count field.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock. One clock; reset is synchronous and active-high.
REQ-004 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req_valid_i, input, 1 bit: read-burst request valid.
REQ-006 SHALL have port req_ready_o, output, 1 bit: burst request accepted when valid&&ready.
REQ-007 SHALL have port req_addr_i, input, vreg_addr_t: first VRF word address.
REQ-008 SHALL have port req_len_i, input, LEN_WIDTH bits: number of words to read.
REQ-009 SHALL have port vrf_raddr_o, output, vreg_addr_t: VRF read address.
REQ-010 SHALL have port vrf_re_o, output, 1 bit: VRF read enable.
REQ-011 SHALL have port vrf_rdata_i, input, vreg_data_t: VRF read data, valid with vrf_rvalid_i.
REQ-012 SHALL have port vrf_rvalid_i, input, 1 bit: VRF read grant/data valid.
REQ-013 SHALL have port op_valid_o, output, 1 bit: operand available.
REQ-014 SHALL have port op_ready_i, input, 1 bit: consumer accepts operand.
REQ-015 SHALL have port op_data_o, output, vreg_data_t: operand word.
REQ-016 SHALL have port op_last_o, output, 1 bit: operand is the final word of its burst.
REQ-017 SHALL have port busy_o, output, 1 bit: burst in progress or buffer non-empty.

Function
REQ-018 SHALL implement FSM states IDLE and READ; req_ready_o = (state==IDLE).
REQ-019 IDLE: on req handshake with req_len_i!=0, SHALL latch address and remaining=req_len_i and go to READ; with req_len_i==0, SHALL consume the request and stay IDLE, no reads.
REQ-020 READ: vrf_re_o SHALL be 1 iff buffer not full; vrf_raddr_o SHALL equal the current address.
REQ-021 A VRF read SHALL complete in a cycle with vrf_re_o&&vrf_rvalid_i; vrf_rdata_i SHALL be pushed into the buffer that cycle, tagged last iff remaining==1.
REQ-022 On completion, address SHALL increment by 1 modulo 2^width(vreg_addr_t) (wrap-around) and remaining SHALL decrement.
REQ-023 Completion with remaining==1 SHALL return to IDLE next cycle; no new request accepted in that completion cycle.
REQ-024 vrf_re_o held without vrf_rvalid_i SHALL keep vrf_raddr_o stable (stall).
REQ-025 Buffer SHALL be FIFO order; op_valid_o = non-empty; pop on op_valid_o&&op_ready_i.
REQ-026 Simultaneous push and pop SHALL be legal when not full, with count unchanged; when full, no push occurs (re gated), pop alone frees a slot and re asserts the next cycle.
REQ-027 Latency: request accepted cycle t -> vrf_re_o cycle t+1 -> op_valid_o earliest cycle t+2 (registered buffer, no bypass).
REQ-028 Throughput: one word per cycle sustained when vrf_rvalid_i and op_ready_i held high and FIFO_DEPTH>=2.
REQ-029 busy_o = (state==READ) || op_valid_o.
REQ-030 op_data_o/op_last_o SHALL be don't-care while op_valid_o=0.

Reset
REQ-031 On rst_i=1 at a clock edge: state=IDLE, buffer empty, remaining=0, address=0.
REQ-032 Outputs during/after reset: req_ready_o=1, vrf_re_o=0, vrf_raddr_o=0, op_valid_o=0, op_last_o=0, busy_o=0.
REQ-033 Reset mid-burst SHALL abort the burst and discard all buffered words; the in-flight VRF read that cycle is dropped.

Structure
REQ-034 vreg_addr_t and vreg_data_t SHALL come from spatz_pkg; default LEN_WIDTH value SHALL be a spatz_pkg constant VrfReadLenWidth.
REQ-035 Buffer SHALL be one sub-module spatz_operand_fifo (data+last, synchronous active-high reset, full/empty/count outputs).

Verification
REQ-036 addr=4, len=3, rvalid=1, op_ready=1 -> raddr 4,5,6 on consecutive cycles; ops D4,D5,D6 from t+2, last only on D6; req_ready back 1 after.
REQ-037 len=0 -> request consumed in one cycle, vrf_re_o never 1, busy_o stays 0.
REQ-038 op_ready=0, len=5, FIFO_DEPTH=2 -> exactly 2 reads then vrf_re_o=0; raising op_ready resumes, all 5 words in order.
REQ-039 rvalid low 3 cycles mid-burst -> raddr held, no duplicate/missing word.
REQ-040 addr=max (all ones), len=2 -> raddr max then 0.
REQ-041 rst_i pulsed after 2 of 4 words -> all outputs at reset values next cycle, no further ops.
